// File: rtl/rc_pwm_pkg.sv
// rc_pwm_pkg: shared constants, channel state encoding and the width-to-
// setpoint scaling used by the RC PWM capture block.
package rc_pwm_pkg;

   localparam int US_PER_MS = 1000;
   localparam int WIDTH_W   = 12;

   // Prescale ratio from a clock frequency to the 1 us tick.
   function automatic int us_div(input int clk_hz);
      return clk_hz / 1000000;
   endfunction

   // Ratio for the nominal 50 MHz system clock.
   localparam int US_DIV = us_div(50000000);

   typedef enum logic [1:0] {
      WAIT_LOW,
      IDLE,
      HIGH,
      ERR
   } ch_state_e;

   // clamp(width, min_us, max_us) - min_us
   function automatic logic [WIDTH_W-1:0] scale_width(
      input logic [WIDTH_W-1:0] width,
      input int                 min_us,
      input int                 max_us
   );
      logic [WIDTH_W-1:0] lo;
      logic [WIDTH_W-1:0] hi;
      lo = WIDTH_W'(min_us);
      hi = WIDTH_W'(max_us);
      if (width <= lo)
         return '0;
      else if (width >= hi)
         return hi - lo;
      else
         return width - lo;
   endfunction

endpackage

// File: rtl/rc_pwm_channel.sv
// rc_pwm_channel: one PWM input. Synchronizes the pin, measures high time in
// us, converts accepted pulses to a setpoint and tracks loss of signal.
// Ports:
//   gclk, rst        clock, synchronous active-high reset
//   pwm              asynchronous PWM pin
//   us_tick, ms_tick shared free-running time base
//   value            setpoint 0..MAX_US-MIN_US (0 when lost)
//   valid            1-cycle strobe, value updates in the same cycle
//   lost             1 = no accepted pulse within TIMEOUT_MS
//   accept           combinational accept, registers into valid next edge
module rc_pwm_channel
   import rc_pwm_pkg::*;
#(
   parameter int MIN_US     = 1000,
   parameter int MAX_US     = 2000,
   parameter int ACC_LO_US  = 800,
   parameter int ACC_HI_US  = 2200,
   parameter int TIMEOUT_MS = 50,
   parameter int VAL_W      = 10
) (
   input  logic             gclk,
   input  logic             rst,
   input  logic             pwm,
   input  logic             us_tick,
   input  logic             ms_tick,
   output logic [VAL_W-1:0] value,
   output logic             valid,
   output logic             lost,
   output logic             accept
);

   localparam int MS_W = $clog2(TIMEOUT_MS + 1);

   logic               sync1, sync2, level_q;
   logic               rise, fall, in_range;
   ch_state_e          state, state_nxt;
   logic [WIDTH_W-1:0] width_cnt, width_nxt;
   logic [WIDTH_W-1:0] scaled;
   logic [MS_W-1:0]    ms_cnt;

   // The chain resets high so a pin that is already high at reset release
   // cannot look like a fresh rising edge; WAIT_LOW then waits it out.
   always_ff @(posedge gclk) begin
      if (rst) begin
         sync1   <= 1'b1;
         sync2   <= 1'b1;
         level_q <= 1'b1;
      end else begin
         sync1   <= pwm;
         sync2   <= sync1;
         level_q <= sync2;
      end
   end

   assign rise     = sync2 & ~level_q;
   assign fall     = ~sync2 & level_q;
   assign in_range = (width_cnt >= WIDTH_W'(ACC_LO_US)) &&
                     (width_cnt <= WIDTH_W'(ACC_HI_US));
   assign scaled   = scale_width(width_cnt, MIN_US, MAX_US);

   always_comb begin
      state_nxt = state;
      width_nxt = width_cnt;
      accept    = 1'b0;
      case (state)
         WAIT_LOW: if (!sync2) state_nxt = IDLE;
         IDLE: begin
            if (rise) begin
               width_nxt = '0;
               state_nxt = HIGH;
            end
         end
         HIGH: begin
            if (fall) begin
               // too-short pulses fall through with accept low
               accept    = in_range;
               state_nxt = IDLE;
            end else if (width_cnt > WIDTH_W'(ACC_HI_US)) begin
               state_nxt = ERR;
            end else if (us_tick && (width_cnt != '1)) begin
               width_nxt = width_cnt + 1'b1;
            end
         end
         ERR:     if (fall) state_nxt = IDLE;
         default: state_nxt = WAIT_LOW;
      endcase
   end

   always_ff @(posedge gclk) begin
      if (rst) begin
         state     <= WAIT_LOW;
         width_cnt <= '0;
         ms_cnt    <= '0;
         value     <= '0;
         valid     <= 1'b0;
         lost      <= 1'b1;
      end else begin
         state     <= state_nxt;
         width_cnt <= width_nxt;
         valid     <= accept;
         // accept takes priority over a timeout landing in the same cycle
         if (accept) begin
            value  <= scaled[VAL_W-1:0];
            ms_cnt <= '0;
            lost   <= 1'b0;
         end else if (ms_tick && (ms_cnt < MS_W'(TIMEOUT_MS))) begin
            ms_cnt <= ms_cnt + 1'b1;
            if (ms_cnt == MS_W'(TIMEOUT_MS - 1)) begin
               lost  <= 1'b1;
               value <= '0;
            end
         end
      end
   end

endmodule

// File: rtl/rc_pwm_capture.sv
// rc_pwm_capture: N_CH-channel RC PWM decoder. Holds the shared us/ms time
// base and the frame_valid aggregation; per-channel work is in rc_pwm_channel.
// Ports:
//   gclk, rst    clock, synchronous active-high reset
//   pwm_in       asynchronous PWM pins, one per channel
//   ch_value     packed setpoints, channel i at [i*VAL_W +: VAL_W]
//   ch_valid     per-channel 1-cycle update strobe
//   ch_lost      per-channel loss-of-signal level
//   frame_valid  1-cycle strobe once every channel updated since the last one
module rc_pwm_capture
   import rc_pwm_pkg::*;
#(
   parameter int CLK_HZ     = 50000000,
   parameter int N_CH       = 4,
   parameter int MIN_US     = 1000,
   parameter int MAX_US     = 2000,
   parameter int ACC_LO_US  = 800,
   parameter int ACC_HI_US  = 2200,
   parameter int TIMEOUT_MS = 50,
   parameter int VAL_W      = 10
) (
   input  logic                  gclk,
   input  logic                  rst,
   input  logic [N_CH-1:0]       pwm_in,
   output logic [N_CH*VAL_W-1:0] ch_value,
   output logic [N_CH-1:0]       ch_valid,
   output logic [N_CH-1:0]       ch_lost,
   output logic                  frame_valid
);

   localparam int DIV   = us_div(CLK_HZ);
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int MS_CW = $clog2(US_PER_MS);

   logic [DIV_W-1:0] div_cnt;
   logic [MS_CW-1:0] us_cnt;
   logic             us_tick, ms_tick;
   logic [N_CH-1:0]  accept;
   logic [N_CH-1:0]  updated;

   // Free-running: pulse edges never restart the time base, hence +-1 us.
   assign us_tick = (div_cnt == DIV_W'(DIV - 1));
   assign ms_tick = us_tick && (us_cnt == MS_CW'(US_PER_MS - 1));

   always_ff @(posedge gclk) begin
      if (rst) begin
         div_cnt <= '0;
         us_cnt  <= '0;
      end else begin
         div_cnt <= us_tick ? '0 : div_cnt + 1'b1;
         if (us_tick)
            us_cnt <= ms_tick ? '0 : us_cnt + 1'b1;
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      rc_pwm_channel #(
         .MIN_US     (MIN_US),
         .MAX_US     (MAX_US),
         .ACC_LO_US  (ACC_LO_US),
         .ACC_HI_US  (ACC_HI_US),
         .TIMEOUT_MS (TIMEOUT_MS),
         .VAL_W      (VAL_W)
      ) u_ch (
         .gclk    (gclk),
         .rst     (rst),
         .pwm     (pwm_in[i]),
         .us_tick (us_tick),
         .ms_tick (ms_tick),
         .value   (ch_value[i*VAL_W +: VAL_W]),
         .valid   (ch_valid[i]),
         .lost    (ch_lost[i]),
         .accept  (accept[i])
      );
   end

   // Flags set on the same edge as ch_valid, so frame_valid lands in the
   // cycle of the last channel's strobe. An accept on the clearing edge
   // survives and counts toward the next frame.
   assign frame_valid = &updated;

   always_ff @(posedge gclk) begin
      if (rst)
         updated <= '0;
      else
         updated <= accept | (updated & ~{N_CH{frame_valid}});
   end

endmodule

// File: tb/tb_rc_pwm_capture.sv
// Scoreboard bench for rc_pwm_capture: stimulus pushes expected setpoints per
// channel, a negedge monitor pops on every ch_valid and also predicts
// frame_valid from the frame rule.
module tb_rc_pwm_capture;

   localparam int CLK_HZ     = 2000000;
   localparam int DIV        = CLK_HZ / 1000000;
   localparam int N_CH       = 4;
   localparam int VAL_W      = 10;
   localparam int TIMEOUT_MS = 5;

   logic                  gclk = 1'b0;
   logic                  rst  = 1'b1;
   logic [N_CH-1:0]       pwm_in = '0;
   logic [N_CH*VAL_W-1:0] ch_value;
   logic [N_CH-1:0]       ch_valid;
   logic [N_CH-1:0]       ch_lost;
   logic                  frame_valid;

   int checks   = 0;
   int failures = 0;
   int exp_q [N_CH][$];
   bit [N_CH-1:0] model_upd = '0;
   int fv_seen = 0;
   int w [N_CH];
   int d [N_CH];
   int f0;

   always #5 gclk = ~gclk;

   rc_pwm_capture #(
      .CLK_HZ     (CLK_HZ),
      .N_CH       (N_CH),
      .MIN_US     (1000),
      .MAX_US     (2000),
      .ACC_LO_US  (800),
      .ACC_HI_US  (2200),
      .TIMEOUT_MS (TIMEOUT_MS),
      .VAL_W      (VAL_W)
   ) dut (
      .gclk        (gclk),
      .rst         (rst),
      .pwm_in      (pwm_in),
      .ch_value    (ch_value),
      .ch_valid    (ch_valid),
      .ch_lost     (ch_lost),
      .frame_valid (frame_valid)
   );

   // Expected setpoint for a pulse of w_us, or -1 when no strobe is due.
   function automatic int ref_value(input int w_us);
      if (w_us < 800 || w_us > 2200) return -1;
      if (w_us < 1000) return 0;
      if (w_us > 2000) return 1000;
      return w_us - 1000;
   endfunction

   function automatic int val_of(input int ch);
      return int'(ch_value[ch*VAL_W +: VAL_W]);
   endfunction

   task automatic check(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic wait_us(input int us);
      repeat (us * DIV) @(negedge gclk);
   endtask

   task automatic pulse(input int ch, input int w_us, input int delay_us);
      int e;
      wait_us(delay_us);
      pwm_in[ch] = 1'b1;
      wait_us(w_us);
      e = ref_value(w_us);
      if (e >= 0) exp_q[ch].push_back(e);
      pwm_in[ch] = 1'b0;
   endtask

   task automatic reset_pulse();
      @(posedge gclk); #1 rst = 1'b1;
      @(posedge gclk); #1 rst = 1'b0;
      @(negedge gclk);
      check("rst_value",       int'(ch_value == '0), 1, 1);
      check("rst_valid",       int'(ch_valid), 0, 0);
      check("rst_lost",        int'(ch_lost), (1 << N_CH) - 1, (1 << N_CH) - 1);
      check("rst_frame_valid", int'(frame_valid), 0, 0);
   endtask

   // Monitor / scoreboard
   initial begin
      int e;
      bit fv_exp;
      forever begin
         @(negedge gclk);
         if (rst) begin
            model_upd = '0;
         end else begin
            for (int i = 0; i < N_CH; i++) begin
               if (ch_valid[i]) begin
                  if (exp_q[i].size() == 0) begin
                     check($sformatf("unexpected_strobe_ch%0d", i), 1, 0, 0);
                  end else begin
                     e = exp_q[i].pop_front();
                     check($sformatf("value_ch%0d", i), val_of(i), e - 1, e + 1);
                     check($sformatf("lost_at_strobe_ch%0d", i), int'(ch_lost[i]), 0, 0);
                     model_upd[i] = 1'b1;
                  end
               end
            end
            fv_exp = &model_upd;
            if (fv_exp || frame_valid)
               check("frame_valid", int'(frame_valid), int'(fv_exp), int'(fv_exp));
            if (frame_valid) fv_seen++;
            if (fv_exp) model_upd = '0;
         end
      end
   end

   initial begin
      #950000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (4) @(negedge gclk);
      check("init_value", int'(ch_value == '0), 1, 1);
      check("init_valid", int'(ch_valid), 0, 0);
      check("init_lost",  int'(ch_lost), (1 << N_CH) - 1, (1 << N_CH) - 1);
      check("init_fv",    int'(frame_valid), 0, 0);
      @(posedge gclk); #1 rst = 1'b0;
      wait_us(10);

      // 1500 us on ch0, strobe exactly 3 cycles after the pin falls
      @(negedge gclk);
      pwm_in[0] = 1'b1;
      wait_us(1500);
      exp_q[0].push_back(ref_value(1500));
      pwm_in[0] = 1'b0;
      @(negedge gclk); @(negedge gclk);
      check("t1_no_early_strobe", int'(ch_valid[0]), 0, 0);
      @(negedge gclk);
      check("t1_strobe_at_3", int'(ch_valid[0]), 1, 1);
      check("t1_lost0", int'(ch_lost[0]), 0, 0);
      check("t1_lost_others", int'(ch_lost[3:1]), 7, 7);
      @(negedge gclk);
      check("t1_strobe_one_cycle", int'(ch_valid[0]), 0, 0);
      wait_us(20);

      // Clamping below/above, then a short reject and a stuck-high pin
      fork
         pulse(0, 900, 0);
         pulse(1, 2100, 0);
      join
      wait_us(20);
      fork
         pulse(0, 700, 0);
         pulse(1, 3000, 0);
      join
      wait_us(20);
      check("t2_reject_keeps_value", val_of(0), 0, 0);
      check("t3_err_keeps_value", val_of(1), 1000, 1000);
      pulse(1, 1200, 0);
      wait_us(20);

      // Two staggered full frames, ch3 is always last
      for (int f = 0; f < 2; f++) begin
         f0 = fv_seen;
         fork
            pulse(0, 1000, 0);
            pulse(1, 1250, 100);
            pulse(2, 1750, 200);
            pulse(3, 2000, 300);
         join
         wait_us(50);
         check($sformatf("t4_frame_count_%0d", f), fv_seen - f0, 1, 1);
      end

      // ch2 goes silent until it times out
      f0 = fv_seen;
      for (int r = 0; r < 4; r++) begin
         fork
            pulse(0, 1500, 0);
            pulse(1, 1500, 0);
            pulse(3, 1500, 0);
         join
         wait_us(100);
         if (r == 0) check("t5_ch2_alive", int'(ch_lost[2]), 0, 0);
      end
      check("t5_ch2_lost", int'(ch_lost[2]), 1, 1);
      check("t5_ch2_failsafe", val_of(2), 0, 0);
      check("t5_no_frames", fv_seen - f0, 0, 0);
      pulse(2, 1300, 0);
      wait_us(20);
      check("t5_ch2_recovered", int'(ch_lost[2]), 0, 0);

      // Reset in the middle of a pulse
      @(negedge gclk);
      pwm_in[0] = 1'b1;
      wait_us(700);
      reset_pulse();
      wait_us(800);
      pwm_in[0] = 1'b0;
      wait_us(50);
      pulse(0, 1500, 0);
      wait_us(20);
      check("t6_ch0_alive", int'(ch_lost[0]), 0, 0);

      // Randomized rounds on all channels
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < N_CH; i++) begin
            w[i] = int'($urandom_range(2197, 803));
            d[i] = int'($urandom_range(200, 0));
         end
         fork
            pulse(0, w[0], d[0]);
            pulse(1, w[1], d[1]);
            pulse(2, w[2], d[2]);
            pulse(3, w[3], d[3]);
         join
         wait_us(50);
      end

      for (int i = 0; i < N_CH; i++)
         check($sformatf("pending_ch%0d", i), exp_q[i].size(), 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
